toeplitz_hash_sched: RTL and testbench

Sequencing controller for the Toeplitz hashing engine. It takes a job start, hands a seed to the shift-seed datapath over the `shift_en`/`seed_ack` handshake, and fetches one raw-data word per pass. It then times the per-row accumulate window for each pass and presents the finished hash to the downstream consumer. It sits between the seed store, the raw-data FIFO, the shift-seed datapath and the row-sum accumulator.

---
 rtl/toeplitz_hash_sched_if.sv | 44 ++++
 rtl/toeplitz_hash_sched.sv | 187 ++++++++++++++++++
 tb/tb_toeplitz_hash_sched.sv | 378 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/toeplitz_hash_sched_if.sv
// Handshake/bus bundle between the Toeplitz hash sequencer and its neighbours
// (seed store, raw-data FIFO, shift-seed datapath, row-sum accumulator and
// the downstream hash consumer).
//   master : the sequencer's view (drives control/status, samples requests)
//   slave  : the environment's view (drives requests/acks, samples control)
// Parameters ROWS/PASSES size the row_idx/pass_idx fields and must match the
// sequencer instance they are connected to.
interface toeplitz_hash_sched_if #(
  parameter int ROWS   = 32,
  parameter int PASSES = 128
);
  localparam int RW = ($clog2(ROWS)   > 0) ? $clog2(ROWS)   : 1;
  localparam int PW = ($clog2(PASSES) > 0) ? $clog2(PASSES) : 1;

  logic          start;
  logic          abort;
  logic          seed_valid;
  logic          seed_take;
  logic          shift_en;
  logic          seed_ack;
  logic          data_req;
  logic          data_valid;
  logic          acc_clr;
  logic          acc_en;
  logic [RW-1:0] row_idx;
  logic [PW-1:0] pass_idx;
  logic          hash_valid;
  logic          hash_ready;
  logic          busy;
  logic          err;
  logic          err_nseed;

  modport master (
    input  start, abort, seed_valid, seed_ack, data_valid, hash_ready,
    output seed_take, shift_en, data_req, acc_clr, acc_en, row_idx,
           pass_idx, hash_valid, busy, err, err_nseed
  );

  modport slave (
    output start, abort, seed_valid, seed_ack, data_valid, hash_ready,
    input  seed_take, shift_en, data_req, acc_clr, acc_en, row_idx,
           pass_idx, hash_valid, busy, err, err_nseed
  );
endinterface

// File: rtl/toeplitz_hash_sched.sv
// Sequencing controller for the Toeplitz hashing engine.
// A job loads a seed into the shift-seed datapath (shift_en/seed_ack),
// then runs PASSES passes; each pass fetches one raw-data word and opens a
// ROWS-cycle accumulate window. The finished hash is offered on
// hash_valid/hash_ready. A seed ack that never arrives within TIMEOUT LOAD
// cycles parks the controller in a sticky error state until abort.
// Ports:
//   clk_in : clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : toeplitz_hash_sched_if.master (start/abort, seed store, datapath,
//            raw-data FIFO, accumulator, result and status signals)
// Every output is a register; level outputs are decoded from the next state
// so they change on the same edge as the state they describe.
module toeplitz_hash_sched #(
  parameter int ROWS    = 32,
  parameter int PASSES  = 128,
  parameter int TIMEOUT = 15
) (
  input  logic                        clk_in,
  input  logic                        rst_n,
  toeplitz_hash_sched_if.master       bus
);
  localparam int RW = ($clog2(ROWS)    > 0) ? $clog2(ROWS)    : 1;
  localparam int PW = ($clog2(PASSES)  > 0) ? $clog2(PASSES)  : 1;
  localparam int TW = ($clog2(TIMEOUT) > 0) ? $clog2(TIMEOUT) : 1;

  localparam logic [RW-1:0] ROW_LAST  = RW'(ROWS - 1);
  localparam logic [PW-1:0] PASS_LAST = PW'(PASSES - 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_FETCH,
    S_ROWS,
    S_PASS_END,
    S_DONE,
    S_ERR
  } state_t;

  state_t        r_state;
  logic [TW-1:0] r_tmo_cnt;
  logic [RW-1:0] r_row_idx;
  logic [PW-1:0] r_pass_idx;
  logic          r_seed_take;
  logic          r_acc_clr;
  logic          r_err_nseed;
  logic          r_shift_en;
  logic          r_data_req;
  logic          r_acc_en;
  logic          r_hash_valid;
  logic          r_busy;
  logic          r_err;

  state_t        w_state_next;
  logic [TW-1:0] w_tmo_next;
  logic [RW-1:0] w_row_next;
  logic [PW-1:0] w_pass_next;
  logic          w_seed_take_next;
  logic          w_acc_clr_next;
  logic          w_err_nseed_next;

  // Next-state, counter and pulse logic.
  always_comb begin
    w_state_next     = r_state;
    w_tmo_next       = r_tmo_cnt;
    w_row_next       = r_row_idx;
    w_pass_next      = r_pass_idx;
    w_seed_take_next = 1'b0;
    w_acc_clr_next   = 1'b0;
    w_err_nseed_next = 1'b0;

    if (bus.abort) begin
      // Abort overrides everything, including a coincident seed_ack, so no
      // seed is ever consumed on an aborted job.
      w_state_next = S_IDLE;
      w_tmo_next   = '0;
      w_row_next   = '0;
      w_pass_next  = '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            if (bus.seed_valid) begin
              w_state_next = S_LOAD;
              w_tmo_next   = '0;
              w_row_next   = '0;
              w_pass_next  = '0;
            end else begin
              w_err_nseed_next = 1'b1;
            end
          end
        end
        S_LOAD: begin
          // Ack is checked before the timeout so an ack on the last allowed
          // LOAD cycle still succeeds.
          if (bus.seed_ack) begin
            w_state_next     = S_FETCH;
            w_seed_take_next = 1'b1;
            w_acc_clr_next   = 1'b1;
            w_pass_next      = '0;
          end else if (r_tmo_cnt == TMO_LAST) begin
            w_state_next = S_ERR;
          end else begin
            w_tmo_next = r_tmo_cnt + 1'b1;
          end
        end
        S_FETCH: begin
          if (bus.data_valid) begin
            w_state_next = S_ROWS;
            w_row_next   = '0;
          end
        end
        S_ROWS: begin
          if (r_row_idx == ROW_LAST) begin
            w_state_next = S_PASS_END;
          end else begin
            w_row_next = r_row_idx + 1'b1;
          end
        end
        S_PASS_END: begin
          if (r_pass_idx == PASS_LAST) begin
            w_state_next = S_DONE;
          end else begin
            w_pass_next  = r_pass_idx + 1'b1;
            w_state_next = S_FETCH;
          end
        end
        S_DONE: begin
          if (bus.hash_ready) begin
            w_state_next = S_IDLE;
          end
        end
        S_ERR: begin
          w_state_next = S_ERR;
        end
        default: begin
          w_state_next = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_tmo_cnt    <= '0;
      r_row_idx    <= '0;
      r_pass_idx   <= '0;
      r_seed_take  <= 1'b0;
      r_acc_clr    <= 1'b0;
      r_err_nseed  <= 1'b0;
      r_shift_en   <= 1'b0;
      r_data_req   <= 1'b0;
      r_acc_en     <= 1'b0;
      r_hash_valid <= 1'b0;
      r_busy       <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_tmo_cnt    <= w_tmo_next;
      r_row_idx    <= w_row_next;
      r_pass_idx   <= w_pass_next;
      r_seed_take  <= w_seed_take_next;
      r_acc_clr    <= w_acc_clr_next;
      r_err_nseed  <= w_err_nseed_next;
      r_shift_en   <= (w_state_next == S_LOAD);
      r_data_req   <= (w_state_next == S_FETCH);
      r_acc_en     <= (w_state_next == S_ROWS);
      r_hash_valid <= (w_state_next == S_DONE);
      r_busy       <= (w_state_next != S_IDLE);
      r_err        <= (w_state_next == S_ERR);
    end
  end

  assign bus.seed_take  = r_seed_take;
  assign bus.shift_en   = r_shift_en;
  assign bus.data_req   = r_data_req;
  assign bus.acc_clr    = r_acc_clr;
  assign bus.acc_en     = r_acc_en;
  assign bus.row_idx    = r_row_idx;
  assign bus.pass_idx   = r_pass_idx;
  assign bus.hash_valid = r_hash_valid;
  assign bus.busy       = r_busy;
  assign bus.err        = r_err;
  assign bus.err_nseed  = r_err_nseed;
endmodule

// File: tb/tb_toeplitz_hash_sched.sv
// Self-checking bench for toeplitz_hash_sched (ROWS=4, PASSES=3, TIMEOUT=8).
// Expected timing comes from a job-level model: hash_valid cycle =
// 3 + ack wait + data waits + PASSES*(ROWS+2), ROWS*PASSES accumulate cycles
// with row/pass indices k%ROWS and k/ROWS, one seed_take/acc_clr per job.
// Cycle n of a job is the n-th clock period after the edge that sampled start.
module tb_toeplitz_hash_sched;
  localparam int ROWS_P    = 4;
  localparam int PASSES_P  = 3;
  localparam int TIMEOUT_P = 8;
  localparam int RW = $clog2(ROWS_P);
  localparam int PW = $clog2(PASSES_P);
  localparam int OW = 9 + RW + PW;
  localparam int BUDGET = 500;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  toeplitz_hash_sched_if #(.ROWS(ROWS_P), .PASSES(PASSES_P)) bus ();

  toeplitz_hash_sched #(
    .ROWS(ROWS_P), .PASSES(PASSES_P), .TIMEOUT(TIMEOUT_P)
  ) dut (
    .clk_in(clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [OW-1:0] all_outs;
  assign all_outs = {bus.seed_take, bus.shift_en, bus.data_req, bus.acc_clr,
                     bus.acc_en, bus.row_idx, bus.pass_idx, bus.hash_valid,
                     bus.busy, bus.err, bus.err_nseed};

  int checks = 0;
  int failures = 0;

  // Per-job stimulus and measurements.
  int waits[PASSES_P];
  int m_hv_first, m_hv_len, m_acc_cnt, m_row_err, m_pass_err;
  int m_take_cnt, m_take_cyc, m_clr_cnt, m_clr_cyc, m_overlap;
  int m_err_seen, m_load_at1, m_busy_drop, m_busy_after;

  function automatic int expected_hv(input int ack_dly);
    int s;
    s = 3 + ack_dly + PASSES_P * (ROWS_P + 2);
    for (int p = 0; p < PASSES_P; p++) s += waits[p];
    return s;
  endfunction

  // Runs one job from IDLE; called at a falling edge, returns at the falling
  // edge of the first IDLE cycle after the result was taken.
  task automatic run_job(input int ack_dly, input int rdy_dly);
    int n, load_cnt, fetch_cnt, pass_seen, done_cnt, need;
    bit hv_seen;
    m_hv_first = -1; m_hv_len = 0; m_acc_cnt = 0; m_row_err = 0; m_pass_err = 0;
    m_take_cnt = 0; m_take_cyc = -1; m_clr_cnt = 0; m_clr_cyc = -1; m_overlap = 0;
    m_err_seen = 0; m_load_at1 = 0; m_busy_drop = 0; m_busy_after = -1;
    load_cnt = 0; fetch_cnt = 0; pass_seen = 0; done_cnt = 0; hv_seen = 0;
    bus.seed_valid = 1'b1;
    bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    n = 1;
    while (1) begin
      if (n == 1 && bus.shift_en) m_load_at1 = 1;
      if (bus.acc_en) begin
        if (int'(bus.row_idx) != m_acc_cnt % ROWS_P) m_row_err++;
        if (int'(bus.pass_idx) != m_acc_cnt / ROWS_P) m_pass_err++;
        m_acc_cnt++;
      end
      if (bus.seed_take) begin m_take_cnt++; m_take_cyc = n; end
      if (bus.acc_clr) begin m_clr_cnt++; m_clr_cyc = n; end
      if (bus.acc_clr && bus.acc_en) m_overlap++;
      if (bus.err) m_err_seen = 1;
      if (bus.hash_valid) begin
        if (!hv_seen) m_hv_first = n;
        hv_seen = 1;
        m_hv_len++;
      end
      if (hv_seen && !bus.hash_valid) begin
        m_busy_after = int'(bus.busy);
        break;
      end
      if (!bus.busy) m_busy_drop++;
      // Datapath: ack on LOAD cycle 2+ack_dly.
      if (bus.shift_en) begin
        load_cnt++;
        bus.seed_ack = (load_cnt == 2 + ack_dly);
      end else begin
        bus.seed_ack = 1'b0;
      end
      // FIFO: waits[p] empty cycles per pass; random noise outside FETCH.
      if (bus.data_req) begin
        need = (pass_seen < PASSES_P) ? waits[pass_seen] : 0;
        bus.data_valid = (fetch_cnt >= need);
        fetch_cnt++;
        if (bus.data_valid) begin pass_seen++; fetch_cnt = 0; end
      end else begin
        bus.data_valid = 1'($urandom_range(0, 1));
        fetch_cnt = 0;
      end
      // Consumer: accept after rdy_dly cycles; random noise elsewhere.
      if (bus.hash_valid) begin
        bus.hash_ready = (done_cnt >= rdy_dly);
        done_cnt++;
      end else begin
        bus.hash_ready = 1'($urandom_range(0, 1));
      end
      n++;
      if (n > BUDGET) break;
      @(negedge clk);
    end
    bus.hash_ready = 1'b0;
    bus.seed_ack   = 1'b0;
    bus.data_valid = 1'b0;
  endtask

  task automatic test_reset();
    bus.start = 0; bus.abort = 0; bus.seed_valid = 0; bus.seed_ack = 0;
    bus.data_valid = 0; bus.hash_ready = 0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (all_outs !== '0) begin
      failures++;
      $display("FAIL reset_outs got=%h want=0", all_outs);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (all_outs !== '0) begin
      failures++;
      $display("FAIL post_reset_outs got=%h want=0", all_outs);
    end
    $display("reset: outs=%h", all_outs);
  endtask

  task automatic test_nominal();
    for (int p = 0; p < PASSES_P; p++) waits[p] = 0;
    @(negedge clk);
    run_job(0, 0);
    $display("nominal: hv_at=%0d acc=%0d take_at=%0d clr_at=%0d", m_hv_first, m_acc_cnt, m_take_cyc, m_clr_cyc);
    checks++;
    if (m_hv_first !== 21) begin failures++; $display("FAIL nom_hv_cycle got=%0d want=21", m_hv_first); end
    checks++;
    if (m_hv_len !== 1) begin failures++; $display("FAIL nom_hv_len got=%0d want=1", m_hv_len); end
    checks++;
    if (m_acc_cnt !== ROWS_P * PASSES_P) begin failures++; $display("FAIL nom_acc_cnt got=%0d want=%0d", m_acc_cnt, ROWS_P * PASSES_P); end
    checks++;
    if (m_row_err + m_pass_err !== 0) begin failures++; $display("FAIL nom_idx_seq row_err=%0d pass_err=%0d want=0", m_row_err, m_pass_err); end
    checks++;
    if (m_take_cnt !== 1 || m_take_cyc !== 3) begin failures++; $display("FAIL nom_seed_take cnt=%0d at=%0d want 1 at 3", m_take_cnt, m_take_cyc); end
    checks++;
    if (m_clr_cnt !== 1 || m_clr_cyc !== 3) begin failures++; $display("FAIL nom_acc_clr cnt=%0d at=%0d want 1 at 3", m_clr_cnt, m_clr_cyc); end
    checks++;
    if (m_overlap !== 0 || m_busy_drop !== 0 || m_load_at1 !== 1) begin
      failures++;
      $display("FAIL nom_misc overlap=%0d busy_drop=%0d load_at1=%0d want 0/0/1", m_overlap, m_busy_drop, m_load_at1);
    end
    checks++;
    if (m_busy_after !== 0) begin failures++; $display("FAIL nom_busy_after got=%0d want=0", m_busy_after); end
  endtask

  task automatic test_data_stall();
    for (int p = 0; p < PASSES_P; p++) waits[p] = 0;
    waits[1] = 2;
    run_job(0, 0);
    $display("stall: hv_at=%0d acc=%0d", m_hv_first, m_acc_cnt);
    checks++;
    if (m_hv_first !== 23) begin failures++; $display("FAIL stall_hv_cycle got=%0d want=23", m_hv_first); end
    checks++;
    if (m_acc_cnt !== 12) begin failures++; $display("FAIL stall_acc_cnt got=%0d want=12", m_acc_cnt); end
  endtask

  task automatic test_ack_last();
    for (int p = 0; p < PASSES_P; p++) waits[p] = 0;
    run_job(TIMEOUT_P - 2, 0);
    $display("ack_last: hv_at=%0d err_seen=%0d", m_hv_first, m_err_seen);
    checks++;
    if (m_hv_first !== expected_hv(TIMEOUT_P - 2)) begin
      failures++;
      $display("FAIL ack_last_hv got=%0d want=%0d", m_hv_first, expected_hv(TIMEOUT_P - 2));
    end
    checks++;
    if (m_err_seen !== 0) begin failures++; $display("FAIL ack_last_err got=%0d want=0", m_err_seen); end
  endtask

  task automatic test_random();
    int ack_dly, rdy_dly, exp_hv;
    for (int j = 0; j < 8; j++) begin
      ack_dly = int'($urandom_range(0, TIMEOUT_P - 2));
      rdy_dly = int'($urandom_range(0, 3));
      for (int p = 0; p < PASSES_P; p++) waits[p] = int'($urandom_range(0, 3));
      exp_hv = expected_hv(ack_dly);
      run_job(ack_dly, rdy_dly);
      $display("random job %0d: ack_dly=%0d rdy_dly=%0d hv_at=%0d exp=%0d acc=%0d",
               j, ack_dly, rdy_dly, m_hv_first, exp_hv, m_acc_cnt);
      checks++;
      if (m_hv_first !== exp_hv) begin failures++; $display("FAIL rnd_hv_cycle job=%0d got=%0d want=%0d", j, m_hv_first, exp_hv); end
      checks++;
      if (m_hv_len !== rdy_dly + 1) begin failures++; $display("FAIL rnd_hv_len job=%0d got=%0d want=%0d", j, m_hv_len, rdy_dly + 1); end
      checks++;
      if (m_acc_cnt !== 12 || m_row_err !== 0 || m_pass_err !== 0) begin
        failures++;
        $display("FAIL rnd_acc job=%0d cnt=%0d row_err=%0d pass_err=%0d want 12/0/0", j, m_acc_cnt, m_row_err, m_pass_err);
      end
      checks++;
      if (m_take_cnt !== 1 || m_take_cyc !== 3 + ack_dly) begin
        failures++;
        $display("FAIL rnd_seed_take job=%0d cnt=%0d at=%0d want 1 at %0d", j, m_take_cnt, m_take_cyc, 3 + ack_dly);
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int p = 0; p < PASSES_P; p++) waits[p] = 0;
    run_job(0, 0);
    run_job(0, 0);
    $display("back_to_back: load_at1=%0d hv_at=%0d", m_load_at1, m_hv_first);
    checks++;
    if (m_load_at1 !== 1 || m_hv_first !== 21) begin
      failures++;
      $display("FAIL b2b_second_job load_at1=%0d hv=%0d want 1/21", m_load_at1, m_hv_first);
    end
  endtask

  task automatic test_timeout();
    int takes;
    takes = 0;
    @(negedge clk);
    bus.seed_valid = 1'b1;
    bus.seed_ack = 1'b0;
    bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    for (int n = 1; n <= 9; n++) begin
      if (bus.seed_take) takes++;
      if (n == 8) begin
        checks++;
        if (bus.err !== 1'b0 || bus.shift_en !== 1'b1) begin
          failures++;
          $display("FAIL tmo_cycle8 err=%b shift_en=%b want 0/1", bus.err, bus.shift_en);
        end
      end
      if (n == 9) begin
        checks++;
        if (bus.err !== 1'b1 || bus.busy !== 1'b1 || bus.shift_en !== 1'b0) begin
          failures++;
          $display("FAIL tmo_cycle9 err=%b busy=%b shift_en=%b want 1/1/0", bus.err, bus.busy, bus.shift_en);
        end
      end else begin
        @(negedge clk);
      end
    end
    repeat (3) @(negedge clk);
    checks++;
    if (bus.err !== 1'b1 || takes !== 0) begin
      failures++;
      $display("FAIL tmo_sticky err=%b takes=%0d want 1/0", bus.err, takes);
    end
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    $display("timeout: after abort outs=%h", all_outs);
    checks++;
    if (all_outs !== '0) begin failures++; $display("FAIL tmo_abort_outs got=%h want=0", all_outs); end
  endtask

  task automatic test_nseed();
    @(negedge clk);
    bus.seed_valid = 1'b0;
    bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    checks++;
    if (bus.err_nseed !== 1'b1 || bus.busy !== 1'b0 || bus.shift_en !== 1'b0) begin
      failures++;
      $display("FAIL nseed_pulse err_nseed=%b busy=%b shift_en=%b want 1/0/0", bus.err_nseed, bus.busy, bus.shift_en);
    end
    @(negedge clk);
    $display("nseed: after pulse outs=%h", all_outs);
    checks++;
    if (all_outs !== '0) begin failures++; $display("FAIL nseed_after got=%h want=0", all_outs); end
    bus.seed_valid = 1'b1;
  endtask

  task automatic test_async_reset();
    int guard;
    @(negedge clk);
    bus.seed_valid = 1'b1;
    bus.seed_ack = 1'b1;
    bus.data_valid = 1'b1;
    bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    guard = 0;
    while (!bus.acc_en && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (bus.acc_en !== 1'b1) begin failures++; $display("FAIL arst_reach_rows acc_en=%b want=1", bus.acc_en); end
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    $display("async_reset: outs=%h", all_outs);
    checks++;
    if (all_outs !== '0) begin failures++; $display("FAIL arst_outs got=%h want=0", all_outs); end
    bus.seed_ack = 1'b0;
    bus.data_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int p = 0; p < PASSES_P; p++) waits[p] = 0;
    run_job(0, 0);
    checks++;
    if (m_hv_first !== 21 || m_acc_cnt !== 12 || m_take_cnt !== 1) begin
      failures++;
      $display("FAIL arst_rerun hv=%0d acc=%0d take=%0d want 21/12/1", m_hv_first, m_acc_cnt, m_take_cnt);
    end
  endtask

  task automatic test_abort_done();
    int guard;
    @(negedge clk);
    bus.seed_valid = 1'b1;
    bus.seed_ack = 1'b1;
    bus.data_valid = 1'b1;
    bus.hash_ready = 1'b0;
    bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    guard = 0;
    while (!bus.hash_valid && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    repeat (3) @(negedge clk);
    checks++;
    if (bus.hash_valid !== 1'b1) begin failures++; $display("FAIL abort_done_held hash_valid=%b want=1", bus.hash_valid); end
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    bus.seed_ack = 1'b0;
    bus.data_valid = 1'b0;
    $display("abort_done: outs=%h", all_outs);
    checks++;
    if (all_outs !== '0) begin failures++; $display("FAIL abort_done_outs got=%h want=0", all_outs); end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog_timeout sim time exceeded");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_nominal();
    test_data_stall();
    test_ack_last();
    test_back_to_back();
    test_random();
    test_timeout();
    test_nseed();
    test_async_reset();
    test_abort_done();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
